id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and WB->ID bypass. Latches decoded
//  operands/control from ID each cycle; drives ex_rs1/ex_rs2 to the forwarding unit and EX operand
//  muxes. Inserts a bubble on load-use hazards and on flush (taken branch/jump resolved in EX).
// PARAMETERS
//  XLEN      32  datapath width (PC, register data, immediate)
//  ALU_OP_W  4   width of ALU operation code
// PORTS
//  clk            in   1         system clock; all state updates on rising edge
//  rst            in   1         synchronous, active-high reset
//  id_valid       in   1         ID holds a real instruction
//  id_pc          in   XLEN      PC of ID instruction
//  id_rs1,id_rs2  in   5 each    source register indices
//  id_uses_rs1/2  in   1 each    instruction actually reads rs1/rs2
//  id_rd          in   5         destination register index
//  id_rs1_data    in   XLEN      regfile read data, port 1
//  id_rs2_data    in   XLEN      regfile read data, port 2
//  id_imm         in   XLEN      sign-extended immediate
//  id_alu_op      in   ALU_OP_W  ALU operation
//  id_alu_src     in   1         1 = operand B is immediate
//  id_mem_read    in   1         load
//  id_mem_write   in   1         store
//  id_reg_write   in   1         writes rd
//  id_mem_to_reg  in   1         WB selects memory data
//  wb_reg_write   in   1         WB-stage write enable
//  wb_rd          in   5         WB-stage destination
//  wb_data        in   XLEN      WB-stage write data
//  flush          in   1         kill instruction in ID (taken branch/jump from EX)
//  stall          out  1         combinational; hold PC and IF/ID register this cycle
//  ex_valid       out  1         EX holds a real instruction
//  ex_pc, ex_imm  out  XLEN      registered copies
//  ex_rs1, ex_rs2, ex_rd  out 5  registered indices (to forwarding unit)
//  ex_rs1_data, ex_rs2_data out XLEN  registered operands (post WB bypass)
//  ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  registered
// BEHAVIOUR
//  - Latency 1 cycle: ID values appear on ex_* the edge after capture.
//  - Reset: every ex_* output = 0 (ex_valid=0, all control 0, indices 0, data 0); stall=0 while rst.
//  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) &
//      ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
//  - stall = hazard & ~flush & ~rst (flush overrides; killed instruction need not wait).
//  - Each edge, priority: rst > flush > hazard > load.
//    flush or hazard: load bubble -- ex_valid=0, ex_reg_write/mem_read/mem_write/mem_to_reg=0,
//      ex_rd=ex_rs1=ex_rs2=0; data/pc/imm fields don't-care (implementation zeroes them).
//    load: capture all id_* into ex_*; ex_valid=id_valid; if id_valid=0 control forced to 0 as bubble.
//  - WB bypass (regfile write-then-read, 3-stage distance not covered by forwarding unit):
//    ex_rs1_data <= (wb_reg_write & wb_rd!=0 & wb_rd==id_rs1) ? wb_data : id_rs1_data; same for rs2.
//  - x0: rd=0 never triggers hazard or bypass; ex_rd=0 results look like no-writer downstream.
//  - A stalled instruction stays in ID (held upstream) and is re-evaluated next cycle; one bubble
//    per load-use pair because the load leaves EX after one cycle.
//  - Reset asserted mid-stall: next edge clears EX; stall drops immediately.
// TESTING
//  1 rst=1 two cycles with random id_* -> all ex_* = 0, stall=0.
//  2 id: add rd=5, rs1=1, rs2=2, data 0x10/0x20 -> next cycle ex_rd=5, ex_rs1_data=0x10, ex_reg_write=1.
//  3 EX holds lw rd=7; ID add rs1=7 uses_rs1=1 -> stall=1 same cycle, next EX bubble (ex_valid=0);
//    following cycle stall=0, add captured.
//  4 Same load-use with flush=1 -> stall=0, EX bubble; lw rd=0 with rs1=0 -> no stall.
//  5 wb_reg_write=1, wb_rd=3, wb_data=0xDEAD, id_rs2=3, id_rs2_data=0x1 -> ex_rs2_data=0xDEAD;
//    wb_rd=0 -> ex_rs2_data=id_rs2_data.
//  6 id_valid=0 with id_reg_write=1 -> ex_valid=0, ex_reg_write=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID instruction, WB write-back port, flush/stall and the
// registered EX-side copies consumed by the forwarding unit and EX operand muxes.
interface id_ex_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                id_valid;
  logic [XLEN-1:0]     id_pc;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [4:0]          id_rd;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_alu_src;
  logic                id_mem_read;
  logic                id_mem_write;
  logic                id_reg_write;
  logic                id_mem_to_reg;

  logic                wb_reg_write;
  logic [4:0]          wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic                flush;
  logic                stall;

  logic                ex_valid;
  logic [XLEN-1:0]     ex_pc;
  logic [XLEN-1:0]     ex_imm;
  logic [4:0]          ex_rs1;
  logic [4:0]          ex_rs2;
  logic [4:0]          ex_rd;
  logic [XLEN-1:0]     ex_rs1_data;
  logic [XLEN-1:0]     ex_rs2_data;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_reg_write;
  logic                ex_mem_to_reg;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, id_mem_to_reg,
           wb_reg_write, wb_rd, wb_data, flush,
    input  stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src, id_mem_read,
           id_mem_write, id_reg_write, id_mem_to_reg,
           wb_reg_write, wb_rd, wb_data, flush,
    output stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data,
           ex_rs2_data, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and a WB->ID operand bypass.
// Flush and load-use hazards both load a bubble; flush also suppresses the stall.

// One source-operand lane: picks the WB write data when it targets this register.
module id_ex_opnd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rdata,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data
);
  logic hit;
  assign hit  = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == rs);
  assign data = hit ? wb_data : rdata;
endmodule

module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  localparam int NUM_OPND = 2;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
  } ctrl_t;

  logic                              ex_valid;
  logic [XLEN-1:0]                   ex_pc;
  logic [XLEN-1:0]                   ex_imm;
  logic [4:0]                        ex_rd;
  logic [NUM_OPND-1:0][4:0]          ex_rs;
  logic [NUM_OPND-1:0][XLEN-1:0]     ex_data;
  ctrl_t                             ex_ctrl;

  logic [NUM_OPND-1:0][4:0]          id_rs;
  logic [NUM_OPND-1:0][XLEN-1:0]     id_data;
  logic [NUM_OPND-1:0][XLEN-1:0]     byp_data;
  logic [NUM_OPND-1:0]               id_uses;
  logic [NUM_OPND-1:0]               rs_match;
  ctrl_t                             id_ctrl;
  logic                              hazard;
  logic                              bubble;

  assign id_rs   = {bus.id_rs2, bus.id_rs1};
  assign id_data = {bus.id_rs2_data, bus.id_rs1_data};
  assign id_uses = {bus.id_uses_rs2, bus.id_uses_rs1};
  assign id_ctrl = '{alu_op:     bus.id_alu_op,
                     alu_src:    bus.id_alu_src,
                     mem_read:   bus.id_mem_read,
                     mem_write:  bus.id_mem_write,
                     reg_write:  bus.id_reg_write,
                     mem_to_reg: bus.id_mem_to_reg};

  genvar g;
  generate
    for (g = 0; g < NUM_OPND; g++) begin : g_opnd
      id_ex_opnd #(.XLEN(XLEN)) u_opnd (
        .rs           (id_rs[g]),
        .rdata        (id_data[g]),
        .wb_reg_write (bus.wb_reg_write),
        .wb_rd        (bus.wb_rd),
        .wb_data      (bus.wb_data),
        .data         (byp_data[g])
      );
      assign rs_match[g] = id_uses[g] & (ex_rd == id_rs[g]);
    end
  endgenerate

  // Load in EX whose result the ID instruction needs: one bubble is enough.
  assign hazard = bus.id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 5'd0) & (|rs_match);
  assign bubble = bus.flush | hazard;
  assign bus.stall = hazard & ~bus.flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_rd    <= '0;
      ex_rs    <= '0;
      ex_data  <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= bus.id_valid;
      ex_pc    <= bus.id_pc;
      ex_imm   <= bus.id_imm;
      ex_rd    <= bus.id_rd;
      ex_rs    <= id_rs;
      ex_data  <= byp_data;
      ex_ctrl  <= bus.id_valid ? id_ctrl : '0;
    end
  end

  assign bus.ex_valid      = ex_valid;
  assign bus.ex_pc         = ex_pc;
  assign bus.ex_imm        = ex_imm;
  assign bus.ex_rd         = ex_rd;
  assign bus.ex_rs1        = ex_rs[0];
  assign bus.ex_rs2        = ex_rs[1];
  assign bus.ex_rs1_data   = ex_data[0];
  assign bus.ex_rs2_data   = ex_data[1];
  assign bus.ex_alu_op     = ex_ctrl.alu_op;
  assign bus.ex_alu_src    = ex_ctrl.alu_src;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
endmodule
